// File: rtl/hermes_input_buffer_if.sv
// Hermes input buffer port bundle.
// Groups the upstream link (rx_i/data_i/credit_o), the switch-control
// handshake (req_o/ack_i/sending_o) and the crossbar side
// (data_o/tx_o/credit_i). The buffer connects through the slave modport;
// its environment connects through the master modport.
interface hermes_input_buffer_if #(
    parameter int FLIT_SIZE = 32
);
    logic                 rx_i;
    logic [FLIT_SIZE-1:0] data_i;
    logic                 credit_o;
    logic                 req_o;
    logic                 ack_i;
    logic                 sending_o;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 tx_o;
    logic                 credit_i;

    modport slave (
        input  rx_i, data_i, ack_i, credit_i,
        output credit_o, req_o, sending_o, data_o, tx_o
    );

    modport master (
        output rx_i, data_i, ack_i, credit_i,
        input  credit_o, req_o, sending_o, data_o, tx_o
    );
endinterface

// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input buffer.
// Circular FIFO of BUFFER_SIZE flits. A small FSM presents the head flit as
// a routing request, waits for the grant, then streams header, size and
// payload towards the crossbar. sending_o stays high while the output port
// is held and falls for at least one cycle between packets.
// Optional build macro HERMES_BUFFER_STATS_EN adds pkt_cnt_o, a 16-bit
// wrapping count of completed packets.
module hermes_input_buffer #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef HERMES_BUFFER_STATS_EN
    output logic [15:0]           pkt_cnt_o,
`endif
    hermes_input_buffer_if.slave  bus
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD
    } state_e;

    state_e               state_q, state_d;
    logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [FLIT_SIZE-1:0] payload_cnt_q, payload_cnt_d;
    logic                 sending_q;
    logic                 not_empty;
    logic                 wr_en;
    logic                 rd_en;
    logic                 tx;

    assign not_empty     = (count_q != '0);
    assign bus.credit_o  = (count_q != FULL_CNT);
    assign wr_en         = bus.rx_i && bus.credit_o;
    assign tx            = not_empty &&
                           (state_q inside {S_HEADER, S_SIZE, S_PAYLOAD});
    assign rd_en         = tx && bus.credit_i;
    assign bus.tx_o      = tx;
    assign bus.data_o    = mem_q[rd_ptr_q];
    assign bus.sending_o = sending_q;

    // Flit storage: write at the write pointer; no bypass to data_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: storage is reset on purpose so data_o reads 0 after reset
            // and a reset mid-packet leaves no stale flits behind.
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    // Pointers wrap naturally; occupancy holds on simultaneous read and write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values,
            // independent of statement order.
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet FSM: next state, payload countdown and routing request.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_d       = state_q;
        payload_cnt_d = payload_cnt_q;
        bus.req_o     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (not_empty) state_d = S_REQ;
            end
            S_REQ: begin
                bus.req_o = 1'b1;
                if (bus.ack_i) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (rd_en) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (rd_en) begin
                    payload_cnt_d = bus.data_o;
                    state_d       = (bus.data_o == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rd_en) begin
                    payload_cnt_d = payload_cnt_q - FLIT_SIZE'(1);
                    if (payload_cnt_q == FLIT_SIZE'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM registers; sending_o is its own flop so it never glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            payload_cnt_q <= '0;
            sending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            payload_cnt_q <= payload_cnt_d;
            sending_q     <= (state_d inside {S_HEADER, S_SIZE, S_PAYLOAD});
        end
    end

`ifdef HERMES_BUFFER_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic        pkt_done;

    assign pkt_done  = (state_d == S_IDLE) &&
                       (state_q inside {S_SIZE, S_PAYLOAD});
    assign pkt_cnt_o = pkt_cnt_q;

    // Completed-packet counter, wraps at 0xFFFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q <= '0;
        end else if (pkt_done) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hermes_input_buffer.sv
// Bench for hermes_input_buffer: stimulus pushes expected flits into a
// scoreboard queue; a monitor pops and compares on every crossbar transfer.
module tb_hermes_input_buffer;
    logic clk_i;
    logic rst_ni;
`ifdef HERMES_BUFFER_STATS_EN
    logic [15:0] pkt_cnt;
`endif

    hermes_input_buffer_if #(.FLIT_SIZE(32)) bus ();

    hermes_input_buffer #(
        .FLIT_SIZE   (32),
        .BUFFER_SIZE (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
`ifdef HERMES_BUFFER_STATS_EN
        .pkt_cnt_o (pkt_cnt),
`endif
        .bus       (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] sb [$];
    int          n_xfer   = 0;
    int          n_send   = 0;
    int          first_xfer_cyc = -1;
    int          last_xfer_cyc  = -1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every flit that crosses towards the crossbar.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (bus.sending_o) n_send++;
                if (bus.tx_o && bus.credit_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_flit: got 0x%0h expected none (cycle %0d)",
                                 bus.data_o, cyc);
                    end else begin
                        check("flit", bus.data_o, sb.pop_front());
                    end
                    if (n_xfer == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    n_xfer++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_flit(input logic [31:0] d, input bit push);
        bus.rx_i   = 1'b1;
        bus.data_i = d;
        if (push) sb.push_back(d);
        tick();
        bus.rx_i   = 1'b0;
    endtask

    task automatic grant();
        for (int i = 0; i < 50 && !bus.req_o; i++) tick();
        check("req_wait", 32'(bus.req_o), 32'd1);
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
    endtask

    task automatic wait_fall(output int fall_cyc);
        for (int i = 0; i < 50 && bus.sending_o; i++) tick();
        check("sending_fall_wait", 32'(bus.sending_o), 32'd0);
        fall_cyc = cyc;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && (sb.size() != 0 || bus.sending_o); i++) tick();
        check("drain_left", 32'(sb.size()), 32'd0);
        check("drain_sending", 32'(bus.sending_o), 32'd0);
    endtask

    task automatic clear_stats();
        n_xfer = 0;
        n_send = 0;
        first_xfer_cyc = -1;
        last_xfer_cyc  = -1;
    endtask

    initial begin
        int fall;
        bus.rx_i     = 1'b0;
        bus.data_i   = '0;
        bus.ack_i    = 1'b0;
        bus.credit_i = 1'b0;
        rst_ni       = 1'b1;
        #1 rst_ni    = 1'b0;
        #2;
        // Reset values
        check("rst_credit", 32'(bus.credit_o), 32'd1);
        check("rst_req", 32'(bus.req_o), 32'd0);
        check("rst_tx", 32'(bus.tx_o), 32'd0);
        check("rst_sending", 32'(bus.sending_o), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        #10 rst_ni = 1'b1;
        tick();

        // Idle: toggling data_i without rx_i stores nothing
        for (int i = 0; i < 4; i++) begin
            bus.data_i = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678;
            tick();
        end
        check("idle_credit", 32'(bus.credit_o), 32'd1);
        check("idle_req", 32'(bus.req_o), 32'd0);
        check("idle_data", bus.data_o, 32'd0);

        // Single packet: header, size 2, 0xA, 0xB; ack 3 cycles after req
        bus.credit_i = 1'b1;
        clear_stats();
        send_flit(32'h0000_0101, 1'b1);
        check("p1_req_not_yet", 32'(bus.req_o), 32'd0);
        tick();
        check("p1_req_rise", 32'(bus.req_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.ack_i = (i == 2);
            send_flit((i == 0) ? 32'd2 : ((i == 1) ? 32'hA : 32'hB), 1'b1);
        end
        bus.ack_i = 1'b0;
        check("p1_sending", 32'(bus.sending_o), 32'd1);
        check("p1_tx", 32'(bus.tx_o), 32'd1);
        check("p1_req_drop", 32'(bus.req_o), 32'd0);
        wait_fall(fall);
        check("p1_xfers", 32'(n_xfer), 32'd4);
        check("p1_consecutive", 32'(last_xfer_cyc - first_xfer_cyc), 32'd3);
        check("p1_fall_cycle", 32'(fall), 32'(last_xfer_cyc + 1));
        check("p1_left", 32'(sb.size()), 32'd0);

        // Fill 8 flits with the crossbar stalled; pointers wrap
        bus.credit_i = 1'b0;
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            send_flit((i == 0) ? 32'h0000_0303 :
                      ((i == 1) ? 32'd6 : 32'(32'h31 + i - 2)), 1'b1);
            if (i == 6) check("fill_credit7", 32'(bus.credit_o), 32'd1);
        end
        check("fill_full", 32'(bus.credit_o), 32'd0);
        send_flit(32'h0000_DEAD, 1'b0);
        check("fill_still_full", 32'(bus.credit_o), 32'd0);
        grant();
        check("fill_tx_stalled", 32'(bus.tx_o), 32'd1);
        check("fill_sending", 32'(bus.sending_o), 32'd1);
        bus.credit_i = 1'b1;
        wait_drain();
        check("fill_xfers", 32'(n_xfer), 32'd8);
        check("fill_credit_back", 32'(bus.credit_o), 32'd1);
        check("fill_tx_idle", 32'(bus.tx_o), 32'd0);

        // Zero-size packet
        clear_stats();
        send_flit(32'h0000_0404, 1'b1);
        send_flit(32'd0, 1'b1);
        grant();
        wait_drain();
        check("zero_xfers", 32'(n_xfer), 32'd2);
        check("zero_sending_cycles", 32'(n_send), 32'd2);

        // Back-to-back packets: one IDLE cycle between sending and next req
        clear_stats();
        send_flit(32'h0000_0501, 1'b1);
        send_flit(32'd1, 1'b1);
        send_flit(32'h0000_0055, 1'b1);
        send_flit(32'h0000_0502, 1'b1);
        send_flit(32'd0, 1'b1);
        grant();
        wait_fall(fall);
        check("b2b_gap_req", 32'(bus.req_o), 32'd0);
        tick();
        check("b2b_req_rise", 32'(bus.req_o), 32'd1);
        check("b2b_sending_low", 32'(bus.sending_o), 32'd0);
        grant();
        wait_drain();
        check("b2b_xfers", 32'(n_xfer), 32'd5);
`ifdef HERMES_BUFFER_STATS_EN
        check("stats_five", 32'(pkt_cnt), 32'd5);
`endif

        // Reset mid-payload
        clear_stats();
        send_flit(32'h0000_0601, 1'b1);
        send_flit(32'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_flit(32'(32'h61 + i), 1'b1);
        grant();
        for (int i = 0; i < 50 && n_xfer < 3; i++) tick();
        check("mid_reached", 32'(n_xfer), 32'd3);
        check("mid_sending", 32'(bus.sending_o), 32'd1);
        #2 rst_ni = 1'b0;
        sb.delete();
        #1;
        check("arst_credit", 32'(bus.credit_o), 32'd1);
        check("arst_req", 32'(bus.req_o), 32'd0);
        check("arst_tx", 32'(bus.tx_o), 32'd0);
        check("arst_sending", 32'(bus.sending_o), 32'd0);
        check("arst_data", bus.data_o, 32'd0);
`ifdef HERMES_BUFFER_STATS_EN
        check("arst_stats", 32'(pkt_cnt), 32'd0);
`endif
        #4 rst_ni = 1'b1;
        tick();
        check("post_rst_req", 32'(bus.req_o), 32'd0);
        check("post_rst_credit", 32'(bus.credit_o), 32'd1);

        // Two complete packets after reset
        clear_stats();
        send_flit(32'h0000_0701, 1'b1);
        send_flit(32'd0, 1'b1);
        grant();
        wait_drain();
        send_flit(32'h0000_0702, 1'b1);
        send_flit(32'd0, 1'b1);
        grant();
        wait_drain();
        check("post_rst_xfers", 32'(n_xfer), 32'd4);
`ifdef HERMES_BUFFER_STATS_EN
        check("stats_two", 32'(pkt_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/hermes_input_buffer.md
# hermes_input_buffer

Per-port input buffer of the Hermes router; one instance sits upstream of each switch-control input port. Stores incoming flits from a neighbour link or the local IP in a circular FIFO, presents the header flit to the switch control as a routing request, and after acknowledgement streams the packet (header, size, payload) towards the crossbar. It drives `sending_o` so the switch control can release the output port when the packet tail leaves.

## Interface
- `FLIT_SIZE`, 32, flit width in bits (minimum 20).
- `BUFFER_SIZE`, 8, FIFO depth in flits; power of two, minimum 4.
- `clk_i` in 1, clock.
- `rst_ni` in 1, reset: asynchronous, active-low.
- `rx_i` in 1, upstream flit valid.
- `data_i` in FLIT_SIZE, upstream flit.
- `credit_o` out 1, FIFO can accept a flit this cycle.
- `req_o` out 1, routing request to switch control.
- `ack_i` in 1, routing grant from switch control; one-cycle pulse.
- `sending_o` out 1, packet being forwarded; the output port is held.
- `data_o` out FLIT_SIZE, FIFO head flit, valid whenever the FIFO is not empty.
- `tx_o` out 1, flit valid towards the crossbar.
- `credit_i` in 1, downstream (crossbar-selected) can accept.

## Operation
- Write: when `rx_i && credit_o`, store at the write pointer and advance it.
- Read: when `tx_o && credit_i`, advance the read pointer.
- Pointers are $clog2(BUFFER_SIZE) bits and wrap naturally. An occupancy counter of $clog2(BUFFER_SIZE)+1 bits updates +1, −1, or 0 on simultaneous read and write.
- `credit_o = (count != BUFFER_SIZE)`. When full, no write is accepted even if a read occurs in the same cycle.
- No bypass: a flit written into an empty FIFO appears on `data_o` the next cycle.
- FSM states and transitions:
  - IDLE: `sending_o`=0. Go to REQ when count≠0.
  - REQ: `req_o`=1, `data_o` is the header. Go to HEADER on `ack_i`.
  - HEADER: `sending_o`=1, `tx_o`=(count≠0). On header transfer, go to SIZE.
  - SIZE: on transfer, latch `data_o[FLIT_SIZE-1:0]` into the payload counter. If the value is 0, go to IDLE; otherwise go to PAYLOAD.
  - PAYLOAD: decrement the counter per transfer. On the transfer when the counter is 1, go to IDLE.
- `req_o` is asserted only in REQ. `tx_o` is asserted only in HEADER, SIZE, and PAYLOAD while the FIFO is not empty.
- `sending_o` = state ∈ {HEADER, SIZE, PAYLOAD}. It is registered from state, never glitching.
- `ack_i` outside REQ is ignored.
- Payload counter is FLIT_SIZE bits, unsigned; no overflow check.

## Timing
- Reset values: `credit_o`=1, `req_o`=0, `sending_o`=0, `tx_o`=0, `data_o`=0 (empty FIFO, storage cleared). State=IDLE, pointers=0, count=0.
- First flit written at edge N: IDLE→REQ at edge N+1, so `req_o` is high from N+1.
- `ack_i` sampled at edge M: header is offered (`tx_o`) in cycle M..M+1.
- Throughput is one flit per cycle while the FIFO is non-empty and `credit_i`=1.
- After the last flit transfer, `sending_o` is low for at least one full cycle (IDLE) before REQ of the next packet. The switch control detects the falling edge and frees the port.
- Reset mid-packet: all state is discarded immediately, including FIFO contents and `sending_o`=0.

## Configuration
- `HERMES_BUFFER_STATS_EN`
  - Defined: adds output `pkt_cnt_o` (16 bits, reset 0), which increments on every FSM transition into IDLE from SIZE or PAYLOAD (packet completed) and wraps at 0xFFFF→0.
  - Undefined: the port and counter do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, then idle:
  - `credit_o`=1 and `req_o`=`tx_o`=`sending_o`=0.
  - `data_i` toggling with `rx_i`=0 leaves count at 0.
- Single packet (header 0x00000101, size 2, payloads 0xA, 0xB), `ack_i` pulsed 3 cycles after `req_o` rises, `credit_i`=1:
  - `tx_o` carries 4 flits in 4 consecutive cycles.
  - `sending_o` falls the cycle after 0xB transfers.
- Fill 8 flits with `credit_i`=0:
  - `credit_o`=0 after the 8th write, and the 9th `rx_i` is not stored.
  - Releasing `credit_i` delivers the flits in order across pointer wrap.
- Zero-size packet (header, size 0): exactly 2 flits forwarded, then IDLE; `sending_o` is high for the 2 transfer cycles only.
- Back-to-back packets in the FIFO: second `req_o` rises one cycle after `sending_o` has been low for exactly one cycle.
- Assert `rst_ni` low mid-payload:
  - All outputs return to reset values asynchronously.
  - With `HERMES_BUFFER_STATS_EN`, `pkt_cnt_o` returns to 0, and it reads 2 after two completed packets.
